// File: rtl/bcp_implication_queue.sv
// Implication queue between the clause BCP checker and the assignment engine:
// buffers unit implications, drops duplicates, and flags conflicting ones.
module bcp_implication_queue #(
  parameter int VAR_NUM = 8,
  parameter int IDX_W   = 3,
  parameter int DEPTH   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     imp_valid,
  input  logic [IDX_W-1:0]         imp_var,
  input  logic                     imp_value,
  output logic                     imp_ready,
  input  logic [VAR_NUM-1:0]       assignment,
  input  logic [VAR_NUM-1:0]       free,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_var,
  output logic                     out_value,
  input  logic                     out_ready,
  output logic                     conflict,
  output logic [IDX_W-1:0]         conflict_var,
  output logic [VAR_NUM-1:0]       pending_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               dup_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CONFLICT
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VAR_NUM-1:0] pend_mask_q, pend_mask_d;
  logic [VAR_NUM-1:0] pend_val_q, pend_val_d;
  logic               conflict_q, conflict_d;
  logic [IDX_W-1:0]   conflict_var_q, conflict_var_d;
  logic [7:0]         dup_q, dup_d;

  logic [IDX_W-1:0]   mem_var_q [DEPTH];
  logic               mem_val_q [DEPTH];
  logic               mem_we;

  logic push_fire, pop_fire;
  logic asg_set, asg_match, pend_hit, pend_match;
  logic is_conflict, is_dup;

  // Handshake flags depend on registered state only.
  assign imp_ready = (state_q == ST_RUN) && (count_q != CNT_W'(DEPTH));
  assign out_valid = (state_q == ST_RUN) && (count_q != '0);
  assign out_var   = mem_var_q[rd_ptr_q];
  assign out_value = mem_val_q[rd_ptr_q];

  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign pending_mask = pend_mask_q;
  assign count        = count_q;
  assign dup_count    = dup_q;

  assign push_fire = imp_valid && imp_ready;
  assign pop_fire  = out_valid && out_ready;

  // Assigned variables take precedence over queued ones; pending state is pre-pop.
  assign asg_set     = ~free[imp_var];
  assign asg_match   = (assignment[imp_var] == imp_value);
  assign pend_hit    = pend_mask_q[imp_var];
  assign pend_match  = (pend_val_q[imp_var] == imp_value);
  assign is_conflict = asg_set ? ~asg_match : (pend_hit && ~pend_match);
  assign is_dup      = asg_set ?  asg_match : (pend_hit &&  pend_match);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    pend_mask_d    = pend_mask_q;
    pend_val_d     = pend_val_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    dup_d          = dup_q;
    mem_we         = 1'b0;

    if (clear || start) begin
      state_d        = clear ? ST_IDLE : ST_RUN;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      pend_mask_d    = '0;
      pend_val_d     = '0;
      conflict_d     = 1'b0;
      conflict_var_d = '0;
      dup_d          = '0;
    end else begin
      if (pop_fire) begin
        rd_ptr_d                        = rd_ptr_q + PTR_W'(1);
        pend_mask_d[mem_var_q[rd_ptr_q]] = 1'b0;
      end
      if (push_fire) begin
        if (is_conflict) begin
          conflict_d     = 1'b1;
          conflict_var_d = imp_var;
          state_d        = ST_CONFLICT;
        end else if (is_dup) begin
          if (dup_q != 8'hFF) dup_d = dup_q + 8'd1;
        end else begin
          mem_we               = 1'b1;
          wr_ptr_d             = wr_ptr_q + PTR_W'(1);
          pend_mask_d[imp_var] = 1'b1;
          pend_val_d[imp_var]  = imp_value;
        end
      end
      count_d = count_q + CNT_W'(mem_we) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pend_mask_q    <= '0;
      pend_val_q     <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      dup_q          <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pend_mask_q    <= pend_mask_d;
      pend_val_q     <= pend_val_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      dup_q          <= dup_d;
    end
  end

  // Storage is reset so the head outputs read zero straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_var_q[i] <= '0;
        mem_val_q[i] <= 1'b0;
      end
    end else if (mem_we) begin
      mem_var_q[wr_ptr_q] <= imp_var;
      mem_val_q[wr_ptr_q] <= imp_value;
    end
  end

endmodule

// File: tb/tb_bcp_implication_queue.sv
// Directed bench for bcp_implication_queue: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_bcp_implication_queue;

  localparam int VAR_NUM = 8;
  localparam int IDX_W   = 3;
  localparam int DEPTH   = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start, clear;
  logic             imp_valid;
  logic [IDX_W-1:0] imp_var;
  logic             imp_value;
  logic             imp_ready;
  logic [VAR_NUM-1:0] assignment, free;
  logic             out_valid;
  logic [IDX_W-1:0] out_var;
  logic             out_value;
  logic             out_ready;
  logic             conflict;
  logic [IDX_W-1:0] conflict_var;
  logic [VAR_NUM-1:0] pending_mask;
  logic [3:0]       count;
  logic [7:0]       dup_count;

  bcp_implication_queue #(.VAR_NUM(VAR_NUM), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear),
    .imp_valid(imp_valid), .imp_var(imp_var), .imp_value(imp_value),
    .imp_ready(imp_ready), .assignment(assignment), .free(free),
    .out_valid(out_valid), .out_var(out_var), .out_value(out_value),
    .out_ready(out_ready), .conflict(conflict), .conflict_var(conflict_var),
    .pending_mask(pending_mask), .count(count), .dup_count(dup_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of implications, state 0=IDLE 1=RUN 2=CONFLICT
  typedef struct { int v; bit p; } ent_t;
  ent_t q[$];
  int   m_state, m_conf, m_cvar, m_dup;
  int   mv, mi;
  bit   mp, m_pop, m_push;

  function automatic int m_find(input int v);
    for (int i = 0; i < q.size(); i++) if (q[i].v == v) return i;
    return -1;
  endfunction

  function automatic int m_pmask();
    int m = 0;
    foreach (q[i]) m |= (1 << q[i].v);
    return m;
  endfunction

  task automatic m_flush(input int st);
    q.delete();
    m_state = st; m_conf = 0; m_cvar = 0; m_dup = 0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) m_flush(0);
    else if (clear) m_flush(0);
    else if (start) m_flush(1);
    else if (m_state == 1) begin
      m_pop  = (q.size() != 0) && out_ready;
      m_push = (q.size() != DEPTH) && imp_valid;
      if (m_push) begin
        mv = int'(imp_var); mp = imp_value; mi = m_find(mv);
        if (!free[mv] || mi >= 0) begin
          if ((!free[mv] && assignment[mv] == mp) || (free[mv] && q[mi].p == mp)) begin
            if (m_dup < 255) m_dup++;
          end else begin
            m_conf = 1; m_cvar = mv; m_state = 2;
          end
          m_push = 0;
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{mv, mp});
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("imp_ready", int'(imp_ready), int'(m_state == 1 && q.size() != DEPTH));
      chk("out_valid", int'(out_valid), int'(m_state == 1 && q.size() != 0));
      chk("count", int'(count), q.size());
      chk("pending_mask", int'(pending_mask), m_pmask());
      chk("conflict", int'(conflict), m_conf);
      chk("conflict_var", int'(conflict_var), m_cvar);
      chk("dup_count", int'(dup_count), m_dup);
      if (out_valid && q.size() != 0) begin
        chk("out_var", int'(out_var), q[0].v);
        chk("out_value", int'(out_value), int'(q[0].p));
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic push(input int v, input bit p);
    imp_valid = 1'b1; imp_var = IDX_W'(v); imp_value = p; cycle();
  endtask

  initial begin
    reset = 1'b1; start = 0; clear = 0; imp_valid = 0; imp_var = 0; imp_value = 0;
    assignment = 8'h00; free = 8'hFF; out_ready = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst imp_ready", int'(imp_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst count", int'(count), 0);
    chk("rst pending", int'(pending_mask), 0);
    chk("rst conflict", int'(conflict), 0);
    chk("rst dup", int'(dup_count), 0);
    chk("rst out_var", int'(out_var), 0);
    chk("rst out_value", int'(out_value), 0);
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    chk("idle imp_ready", int'(imp_ready), 0);

    // Basic enqueue and ordered drain
    pulse_start();
    chk("run imp_ready", int'(imp_ready), 1);
    push(3, 1); push(5, 0); imp_valid = 0;
    chk("t1 count", int'(count), 2);
    chk("t1 pending", int'(pending_mask), 8'h28);
    chk("t1 head var", int'(out_var), 3);
    out_ready = 1; cycle();
    chk("t1 pop1 var", int'(out_var), 5);
    chk("t1 pop1 value", int'(out_value), 0);
    cycle();
    chk("t1 empty count", int'(count), 0);
    chk("t1 empty pending", int'(pending_mask), 0);
    out_ready = 0;
    $display("scenario basic done: count=%0d", count);

    // Duplicate against pending, then opposite polarity conflict
    pulse_start();
    push(2, 1); push(2, 1);
    chk("t2 count", int'(count), 1);
    chk("t2 dup", int'(dup_count), 1);
    push(2, 0); imp_valid = 0;
    chk("t2 conflict", int'(conflict), 1);
    chk("t2 conflict_var", int'(conflict_var), 2);
    chk("t2 imp_ready", int'(imp_ready), 0);
    chk("t2 out_valid", int'(out_valid), 0);
    cycle();
    chk("t2 frozen count", int'(count), 1);
    $display("scenario pending-dup done: conflict_var=%0d", conflict_var);

    // Duplicate and conflict against the current assignment
    pulse_start();
    chk("t3 conflict cleared", int'(conflict), 0);
    free = 8'hEF; assignment = 8'h10;
    push(4, 1);
    chk("t3 dup", int'(dup_count), 1);
    chk("t3 count", int'(count), 0);
    push(4, 0); imp_valid = 0;
    chk("t3 conflict_var", int'(conflict_var), 4);
    free = 8'hFF; assignment = 8'h00;
    $display("scenario assigned done: conflict_var=%0d", conflict_var);

    // Fill to full, blocked push, one pop, then ordered drain across the wrap
    pulse_start();
    for (int i = 0; i < DEPTH; i++) push(i, bit'(i & 1));
    push(0, 0); cycle();
    chk("t4 count full", int'(count), 8);
    chk("t4 imp_ready full", int'(imp_ready), 0);
    chk("t4 dup blocked", int'(dup_count), 0);
    out_ready = 1; cycle();
    out_ready = 0; imp_valid = 0;
    chk("t4 count after pop", int'(count), 7);
    chk("t4 imp_ready after pop", int'(imp_ready), 1);
    chk("t4 head var", int'(out_var), 1);
    out_ready = 1;
    for (int i = 0; i < 7; i++) cycle();
    out_ready = 0;
    chk("t4 drained", int'(count), 0);
    $display("scenario full done: count=%0d", count);

    // Pop of head and conflicting push of the same variable in one cycle
    pulse_start();
    push(6, 1);
    out_ready = 1; push(6, 0);
    imp_valid = 0; out_ready = 0;
    chk("t5 conflict", int'(conflict), 1);
    chk("t5 conflict_var", int'(conflict_var), 6);
    chk("t5 count", int'(count), 0);
    chk("t5 pending", int'(pending_mask), 0);
    pulse_start();
    chk("t5 restart conflict", int'(conflict), 0);
    chk("t5 restart imp_ready", int'(imp_ready), 1);
    $display("scenario pop-conflict done: conflict=%0d", conflict);

    // clear beats start and a push in the same cycle
    push(1, 1);
    clear = 1; start = 1; imp_valid = 1; imp_var = 3'd2; imp_value = 1;
    cycle();
    clear = 0; start = 0; imp_valid = 0;
    chk("t6 imp_ready", int'(imp_ready), 0);
    chk("t6 count", int'(count), 0);
    chk("t6 out_valid", int'(out_valid), 0);
    $display("scenario clear done: count=%0d", count);

    // Asynchronous reset in the middle of a cycle
    pulse_start();
    push(1, 1); push(1, 1); push(2, 0); push(3, 1); imp_valid = 0;
    chk("t7 count", int'(count), 3);
    chk("t7 dup", int'(dup_count), 1);
    #2 reset = 1'b0;
    #1;
    chk("t7 rst count", int'(count), 0);
    chk("t7 rst pending", int'(pending_mask), 0);
    chk("t7 rst dup", int'(dup_count), 0);
    chk("t7 rst out_valid", int'(out_valid), 0);
    chk("t7 rst imp_ready", int'(imp_ready), 0);
    chk("t7 rst out_var", int'(out_var), 0);
    cycle();
    reset = 1'b1;
    cycle(); cycle();
    $display("scenario reset done: count=%0d", count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
